// File: rtl/car_lane_ctrl.sv
// Player-car controller: buffered move request, per-step move/collide check, IDLE/RUN/CRASH FSM, saturating score.
// Latency: outputs update on the edge that samples step/start. Backpressure: move_ready is high only in RUN.
module car_lane_ctrl #(
    parameter int LANES      = 6,
    parameter int POS_W      = 3,
    parameter int START_LANE = 2,
    parameter int SCORE_W    = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               step,
    input  logic               move_valid,
    input  logic [1:0]         move_dir,
    output logic               move_ready,
    input  logic [LANES-1:0]   next_row,
    input  logic [LANES-1:0]   head_row,
    output logic [POS_W-1:0]   position,
    output logic               alive,
    output logic               crash,
    output logic [SCORE_W-1:0] score
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_CRASH} state_t;

    localparam logic [POS_W-1:0]   LAST_COL  = POS_W'(LANES - 1);
    localparam logic [POS_W-1:0]   START_COL = POS_W'(START_LANE);
    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

    state_t             state_q;
    logic [POS_W-1:0]   pos_q;
    logic [SCORE_W-1:0] score_q;
    logic               alive_q;
    logic               crash_q;
    logic [1:0]         buf_q;

    logic [1:0]       dir_d;
    logic [POS_W-1:0] tgt_d;
    logic             side_d;
    logic             hit_d;

    assign move_ready = (state_q == S_RUN);
    assign position   = pos_q;
    assign score      = score_q;
    assign alive      = alive_q;
    assign crash      = crash_q;

    // Neighbour columns are only formed away from the edges; at an edge the move clamps to "up".
    always_comb begin
        dir_d  = (move_valid && move_ready) ? move_dir : buf_q;
        tgt_d  = pos_q;
        side_d = 1'b0;
        if (dir_d == 2'b10 && pos_q != LAST_COL) begin
            tgt_d  = pos_q + POS_W'(1);
            side_d = 1'b1;
        end else if (dir_d == 2'b01 && pos_q != '0) begin
            tgt_d  = pos_q - POS_W'(1);
            side_d = 1'b1;
        end
        hit_d = next_row[tgt_d] | (side_d & head_row[tgt_d]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            pos_q   <= START_COL;
            score_q <= '0;
            alive_q <= 1'b0;
            crash_q <= 1'b0;
            buf_q   <= 2'b00;
        end else begin
            crash_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    pos_q   <= START_COL;
                    score_q <= '0;
                    buf_q   <= 2'b00;
                    if (start) begin
                        state_q <= S_RUN;
                        alive_q <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (step) begin
                        buf_q <= 2'b00;
                        if (hit_d) begin
                            state_q <= S_CRASH;
                            alive_q <= 1'b0;
                            crash_q <= 1'b1;
                        end else begin
                            pos_q <= tgt_d;
                            if (score_q != SCORE_MAX) score_q <= score_q + SCORE_W'(1);
                        end
                    end else if (move_valid) begin
                        buf_q <= move_dir;
                    end
                end
                S_CRASH: begin
                    if (start) begin
                        state_q <= S_RUN;
                        alive_q <= 1'b1;
                        pos_q   <= START_COL;
                        score_q <= '0;
                        buf_q   <= 2'b00;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_car_lane_ctrl.sv
// Directed bench for car_lane_ctrl (LANES=6, SCORE_W=2): expected outputs queued per driven cycle, compared after the edge.
module tb_car_lane_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       step = 1'b0;
    logic       move_valid = 1'b0;
    logic [1:0] move_dir = 2'b00;
    logic       move_ready;
    logic [5:0] next_row = '0;
    logic [5:0] head_row = '0;
    logic [2:0] position;
    logic       alive;
    logic       crash;
    logic [1:0] score;

    int n_chk = 0;
    int n_fail = 0;

    typedef struct {
        string      tag;
        logic [2:0] pos;
        logic       alive;
        logic       crash;
        logic [1:0] score;
        logic       rdy;
    } exp_t;

    exp_t exp_q[$];

    localparam logic [1:0] UP = 2'b00, LF = 2'b10, RT = 2'b01, XX = 2'b11;

    car_lane_ctrl #(.LANES(6), .POS_W(3), .START_LANE(2), .SCORE_W(2)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .step(step),
        .move_valid(move_valid), .move_dir(move_dir), .move_ready(move_ready),
        .next_row(next_row), .head_row(head_row), .position(position),
        .alive(alive), .crash(crash), .score(score)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, want);
        end
    endtask

    task automatic check_outs(input string tag, input logic [2:0] p, input logic a, input logic c,
                              input logic [1:0] s, input logic r);
        check({tag, ".pos"},   32'(position),   32'(p));
        check({tag, ".alive"}, 32'(alive),      32'(a));
        check({tag, ".crash"}, 32'(crash),      32'(c));
        check({tag, ".score"}, 32'(score),      32'(s));
        check({tag, ".rdy"},   32'(move_ready), 32'(r));
    endtask

    // One driven cycle: inputs applied on the falling edge, expectation queued, outputs compared just after the rising edge.
    task automatic cyc(input string tag, input logic st, input logic sp, input logic mv, input logic [1:0] d,
                       input logic [5:0] nr, input logic [5:0] hr,
                       input logic [2:0] ep, input logic ea, input logic ec, input logic [1:0] es, input logic er);
        exp_t e;
        @(negedge clk);
        start = st; step = sp; move_valid = mv; move_dir = d; next_row = nr; head_row = hr;
        exp_q.push_back('{tag, ep, ea, ec, es, er});
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL %s: scoreboard empty got 0 expected 1", tag);
        end else begin
            e = exp_q.pop_front();
            check_outs(e.tag, e.pos, e.alive, e.crash, e.score, e.rdy);
        end
    endtask

    initial begin
        #12;
        check_outs("reset", 3'd2, 1'b0, 1'b0, 2'd0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        //  tag            st sp mv dir nr         hr          pos a c s r
        cyc("idle_ign",    0, 1, 1, LF, 6'b000000, 6'b000000, 3'd2, 0, 0, 0, 0);
        cyc("start",       1, 0, 0, UP, 6'b000000, 6'b000000, 3'd2, 1, 0, 0, 1);
        cyc("step_up",     0, 1, 0, UP, 6'b000000, 6'b000000, 3'd2, 1, 0, 1, 1);
        cyc("acc_left",    0, 0, 1, LF, 6'b000000, 6'b000000, 3'd2, 1, 0, 1, 1);
        cyc("step_left",   0, 1, 0, UP, 6'b000000, 6'b000000, 3'd3, 1, 0, 2, 1);
        cyc("acc_l",       0, 0, 1, LF, 6'b000000, 6'b000000, 3'd3, 1, 0, 2, 1);
        cyc("acc_r",       0, 0, 1, RT, 6'b000000, 6'b000000, 3'd3, 1, 0, 2, 1);
        cyc("last_wins",   0, 1, 0, UP, 6'b000000, 6'b000000, 3'd2, 1, 0, 3, 1);
        cyc("bypass",      0, 1, 1, LF, 6'b000000, 6'b000000, 3'd3, 1, 0, 3, 1);
        cyc("buf_empty",   0, 1, 0, UP, 6'b010100, 6'b010100, 3'd3, 1, 0, 3, 1);
        cyc("dir11_up",    0, 1, 1, XX, 6'b010100, 6'b010100, 3'd3, 1, 0, 3, 1);
        cyc("acc_l2",      0, 0, 1, LF, 6'b000000, 6'b000000, 3'd3, 1, 0, 3, 1);
        cyc("to_4",        0, 1, 0, UP, 6'b000000, 6'b000000, 3'd4, 1, 0, 3, 1);
        cyc("to_5",        0, 1, 1, LF, 6'b000000, 6'b000000, 3'd5, 1, 0, 3, 1);
        cyc("lclamp_ok",   0, 1, 1, LF, 6'b000000, 6'b000000, 3'd5, 1, 0, 3, 1);
        cyc("lclamp_hit",  0, 1, 1, LF, 6'b100000, 6'b000000, 3'd5, 0, 1, 3, 0);
        cyc("crash_hold",  0, 1, 1, RT, 6'b000000, 6'b000000, 3'd5, 0, 0, 3, 0);
        cyc("restart",     1, 0, 0, UP, 6'b000000, 6'b000000, 3'd2, 1, 0, 0, 1);
        cyc("to_1",        0, 1, 1, RT, 6'b000000, 6'b000000, 3'd1, 1, 0, 1, 1);
        cyc("tail_hit",    0, 1, 1, RT, 6'b000000, 6'b000001, 3'd1, 0, 1, 1, 0);
        cyc("start_wins",  1, 1, 0, UP, 6'b111111, 6'b111111, 3'd2, 1, 0, 0, 1);
        cyc("r_to_1",      0, 1, 1, RT, 6'b000000, 6'b000000, 3'd1, 1, 0, 1, 1);
        cyc("r_to_0",      0, 1, 1, RT, 6'b000000, 6'b000000, 3'd0, 1, 0, 2, 1);
        cyc("rclamp_ok",   0, 1, 1, RT, 6'b000010, 6'b000010, 3'd0, 1, 0, 3, 1);
        cyc("rclamp_hit",  0, 1, 1, RT, 6'b000001, 6'b000000, 3'd0, 0, 1, 3, 0);
        cyc("restart2",    1, 0, 0, UP, 6'b000000, 6'b000000, 3'd2, 1, 0, 0, 1);
        cyc("up_hit",      0, 1, 0, UP, 6'b000100, 6'b000000, 3'd2, 0, 1, 0, 0);
        cyc("restart3",    1, 0, 0, UP, 6'b000000, 6'b000000, 3'd2, 1, 0, 0, 1);
        cyc("lhead_hit",   0, 1, 1, LF, 6'b000000, 6'b001000, 3'd2, 0, 1, 0, 0);
        cyc("restart4",    1, 0, 0, UP, 6'b000000, 6'b000000, 3'd2, 1, 0, 0, 1);
        cyc("run_left",    0, 1, 1, LF, 6'b000000, 6'b000000, 3'd3, 1, 0, 1, 1);
        cyc("arm_left",    0, 0, 1, LF, 6'b000000, 6'b000000, 3'd3, 1, 0, 1, 1);

        // Asynchronous abort in the middle of a running game, with a crashing step pending.
        @(negedge clk);
        start = 0; step = 1; move_valid = 0; next_row = 6'b111111; head_row = 6'b111111;
        #2;
        rst_n = 1'b0;
        #1;
        check_outs("async_rst", 3'd2, 1'b0, 1'b0, 2'd0, 1'b0);
        @(posedge clk);
        #1;
        check_outs("rst_held", 3'd2, 1'b0, 1'b0, 2'd0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc("post_rst",    0, 1, 1, LF, 6'b000000, 6'b000000, 3'd2, 0, 0, 0, 0);
        cyc("post_start",  1, 0, 0, UP, 6'b000000, 6'b000000, 3'd2, 1, 0, 0, 1);
        cyc("buf_cleared", 0, 1, 0, UP, 6'b001000, 6'b001000, 3'd2, 1, 0, 1, 1);

        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/car_lane_ctrl.md
Name: car_lane_ctrl

Overview:
- Parametrised player-car controller for the lane-dodging game.
- Generalises the single-cycle move/collide check to LANES columns.
- Adds a buffered move request with valid/ready handshake, an IDLE/RUN/CRASH state machine, a one-cycle crash pulse and a saturating survival score.
- Sits between the button debouncer and the road-row generator/7-seg display; evaluated once per road step.

Parameters:
- LANES, 6, number of road columns; bit i of a row vector is column i; left = higher index.
- POS_W, 3, width of position; must satisfy 2^POS_W >= LANES.
- START_LANE, 2, column loaded on start/restart; must be < LANES.
- SCORE_W, 8, width of survival score counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle pulse: begin game from IDLE or restart from CRASH.
- step  in  1  single-cycle pulse: road advances one row; the move is evaluated this cycle.
- move_valid  in  1  move request present.
- move_dir  in  2  00 up, 10 left, 01 right, 11 treated as up.
- move_ready  out  1  controller accepts move requests.
- next_row  in  LANES  obstacle bits of the row the car enters.
- head_row  in  LANES  obstacle bits of the row the car currently occupies.
- position  out  POS_W  current car column.
- alive  out  1  1 while in RUN.
- crash  out  1  one-cycle pulse on collision.
- score  out  SCORE_W  steps survived this game.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, position=START_LANE, alive=0, crash=0, score=0, move buffer empty (dir=00). Reset mid-game aborts immediately with no crash pulse.
- States:
  - IDLE: waits for start → RUN. position=START_LANE, score=0, buffer cleared.
  - RUN: evaluates moves on each step. A collision → CRASH.
  - CRASH: position frozen at the column occupied when the collision was detected; score frozen. start → RUN with position=START_LANE, score=0, buffer cleared.
- move_ready=1 only in RUN. A request is accepted when move_valid && move_ready.
- One-entry move buffer; last accepted request wins. The buffer empties (reverts to up) after each step.
- If move_valid && move_ready && step occur in the same cycle, the incoming move_dir bypasses the buffer and is used for that step.
- step is ignored in IDLE and CRASH. step and start together in CRASH: start wins, step ignored.
- Evaluation on step (p = position):
  - up: crash if next_row[p]; else p unchanged.
  - left, p != LANES-1: crash if next_row[p+1] | head_row[p+1]; else p := p+1.
  - left, p == LANES-1 (edge clamp): crash if next_row[p]; else p unchanged.
  - right, p != 0: crash if next_row[p-1] | head_row[p-1]; else p := p-1.
  - right, p == 0 (edge clamp): crash if next_row[p]; else p unchanged.
- Latency: position, score, alive and crash update on the clock edge that samples step; they are visible the cycle after step.
- Crash timing: crash=1 for exactly one cycle. alive goes 0 in the same cycle. position is not updated on a crashing step.
- Score: +1 on each non-crashing step in RUN; saturates at 2^SCORE_W-1 (no wrap).
- Row inputs are sampled only on step cycles; they are don't-care otherwise.
- All arithmetic uses POS_W-bit unsigned values; p+1 and p-1 are never formed at the edges.

Test Plan:
- Reset then start, LANES=6: position=2, alive=1, score=0, move_ready=1. step with next_row=000000 and no move → position=2, score=1.
- Accept left, then step with rows clear → position=3. Accept left then right before one step (last wins) → position=2.
- position=5, left, next_row=000000 → position=5. Repeat with next_row=100000 → crash pulse 1 cycle, alive=0, position=5, move_ready=0.
- position=1, right, head_row=000001 → crash (tail collision). Then start → position=2, score=0, alive=1.
- move_valid(left) and step in the same cycle with an empty buffer, rows clear → position=3 (bypass).
- SCORE_W=2: 5 clear steps → score 3 (saturated). Assert rst_n=0 mid-RUN → outputs return to reset values at once, with no crash pulse.
